// File: rtl/rc4_pkg.sv
// Shared constants and FSM state encoding for the RC4 key-search datapath
// (message checker and key-search controller).
package rc4_pkg;

    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SET_ADDR  = 3'd1,
        WAIT_DATA = 3'd2,
        CAPTURE   = 3'd3,
        CHECK     = 3'd4,
        DONE      = 3'd5
    } state_t;

endpackage

// File: rtl/message_checker_char_classifier.sv
// Flags a decrypted byte as legal plaintext: 'a'..'z', plus space when
// MSG_ALLOW_SPACE_EN is defined.
module char_classifier
    import rc4_pkg::*;
(
    input  logic [7:0] data,
    output logic       legal
);

    always_comb begin
        legal = (data >= CHAR_LO) && (data <= CHAR_HI);
`ifdef MSG_ALLOW_SPACE_EN
        if (data == CHAR_SPACE) legal = 1'b1;
`else
        legal = legal;
`endif
    end

endmodule

// File: rtl/message_checker.sv
// Walks D RAM bytes 0..MSG_LEN-1 and reports whether every byte is legal
// plaintext. Optional feature macro: MSG_ALLOW_SPACE_EN (space is legal).
module message_checker
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       finish,
    output logic [7:0] address_d,
    input  logic [7:0] q_d,
    output logic       valid,
    output logic [7:0] fail_index
);

    if (MSG_LEN < 1 || MSG_LEN > 256) begin : g_bad_len
        $error("message_checker: MSG_LEN out of range 1..256");
    end

    // 9-bit index so MSG_LEN=256 reaches its last byte without wrapping.
    localparam logic [8:0] LAST_IDX = 9'(MSG_LEN - 1);

    state_t     state;
    logic [8:0] index;
    logic [7:0] data;
    logic       legal;

    char_classifier u_classifier (
        .data  (data),
        .legal (legal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            index      <= 9'd0;
            address_d  <= 8'd0;
            data       <= 8'd0;
            finish     <= 1'b0;
            valid      <= 1'b0;
            fail_index <= 8'd0;
        end else begin
            finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        index <= 9'd0;
                        valid <= 1'b1;
                        state <= SET_ADDR;
                    end
                end
                SET_ADDR: begin
                    address_d <= index[7:0];
                    state     <= WAIT_DATA;
                end
                // RAM registers the address, so data is ready one cycle later.
                WAIT_DATA: state <= CAPTURE;
                CAPTURE: begin
                    data  <= q_d;
                    state <= CHECK;
                end
                CHECK: begin
                    if (!legal) begin
                        valid      <= 1'b0;
                        fail_index <= index[7:0];
                        finish     <= 1'b1;
                        state      <= DONE;
                    end else if (index == LAST_IDX) begin
                        fail_index <= 8'd0;
                        finish     <= 1'b1;
                        state      <= DONE;
                    end else begin
                        index <= index + 9'd1;
                        state <= SET_ADDR;
                    end
                end
                // finish is high exactly for the DONE cycle; start here is ignored.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_message_checker.sv
// Randomized self-checking bench for message_checker (MSG_LEN=32 and 256 instances).
module tb_message_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_drv = 1'b0;
    bit         cur = 1'b0;
    int         checks = 0;
    int         errors = 0;

    logic       start0, start1, fin0, fin1, v0, v1;
    logic [7:0] a0, a1, q0, q1, f0, f1;
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic       fin_m, valid_m;
    logic [7:0] addr_m, fi_m;

    always #5 clk = ~clk;

    assign start0  = !cur && start_drv;
    assign start1  = cur && start_drv;
    assign fin_m   = cur ? fin1 : fin0;
    assign valid_m = cur ? v1 : v0;
    assign addr_m  = cur ? a1 : a0;
    assign fi_m    = cur ? f1 : f0;

    always @(posedge clk) begin
        q0 <= mem0[a0];
        q1 <= mem1[a1];
    end

    message_checker #(.MSG_LEN(32)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .finish(fin0),
        .address_d(a0), .q_d(q0), .valid(v0), .fail_index(f0)
    );

    message_checker #(.MSG_LEN(256)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .finish(fin1),
        .address_d(a1), .q_d(q1), .valid(v1), .fail_index(f1)
    );

    function automatic bit legal_ref(input logic [7:0] b);
`ifdef MSG_ALLOW_SPACE_EN
        if (b == 8'h20) return 1'b1;
`endif
        return (b >= 8'h61) && (b <= 8'h7A);
    endfunction

    // Reference: the pass reads up to and including the first illegal byte.
    function automatic void model(input int len, output bit v, output int fi, output int reads);
        logic [7:0] b;
        v = 1'b1; fi = 0; reads = len;
        for (int i = 0; i < len; i++) begin
            b = cur ? mem1[i] : mem0[i];
            if (!legal_ref(b)) begin
                v = 1'b0; fi = i; reads = i + 1;
                break;
            end
        end
    endfunction

    function automatic logic [7:0] rnd_byte();
        logic [7:0] b;
        if ($urandom_range(99) < 97) return 8'h61 + 8'($urandom_range(25));
        do b = 8'($urandom); while (legal_ref(b));
        return b;
    endfunction

    // Pulse (or hold) start, then count cycles from the sampling edge until finish.
    task automatic run_pass(input int maxc, input bit hold, input int poke,
                            output int cyc, output int nreads, output int seqerr,
                            output logic vo, output logic [7:0] fo, output logic fin_after);
        int last;
        @(negedge clk); start_drv = 1'b1;
        @(negedge clk); cyc = 1; if (!hold) start_drv = 1'b0;
        last = -1; nreads = 0; seqerr = 0;
        forever begin
            if (cyc >= 2 && int'(addr_m) != last) begin
                if (int'(addr_m) != nreads) seqerr++;
                last = int'(addr_m);
                nreads++;
            end
            if (fin_m === 1'b1 || cyc >= maxc) break;
            start_drv = hold || (cyc == poke);
            @(negedge clk); cyc++;
        end
        vo = valid_m; fo = fi_m;
        @(negedge clk); fin_after = fin_m;
        if (!hold) start_drv = 1'b0;
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        #1;
        checks++; if ({fin0, v0, f0, a0} !== 18'd0) begin errors++; $display("FAIL reset_dut0: got fin=%b valid=%b fi=%0d addr=%0d, want all 0", fin0, v0, f0, a0); end
        checks++; if ({fin1, v1, f1, a1} !== 18'd0) begin errors++; $display("FAIL reset_dut1: got fin=%b valid=%b fi=%0d addr=%0d, want all 0", fin1, v1, f1, a1); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if ({fin0, v0, a0} !== 10'd0) begin errors++; $display("FAIL idle_no_start: got fin=%b valid=%b addr=%0d, want 0", fin0, v0, a0); end
    endtask

    task automatic test_all_legal();
        int cyc, nr, se; logic vo, fa; logic [7:0] fo;
        cur = 1'b0;
        for (int i = 0; i < 256; i++) mem0[i] = 8'h61 + 8'(i % 26);
        run_pass(300, 1'b0, 0, cyc, nr, se, vo, fo, fa);
        checks++; if (cyc !== 129) begin errors++; $display("FAIL legal_latency: got %0d want 129", cyc); end
        checks++; if (vo !== 1'b1) begin errors++; $display("FAIL legal_valid: got %b want 1", vo); end
        checks++; if (fo !== 8'd0) begin errors++; $display("FAIL legal_fail_index: got %0d want 0", fo); end
        checks++; if (nr !== 32 || se !== 0) begin errors++; $display("FAIL legal_reads: got %0d reads %0d out-of-order, want 32 and 0", nr, se); end
        checks++; if (fa !== 1'b0) begin errors++; $display("FAIL legal_finish_pulse: finish still %b next cycle, want 0", fa); end
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL legal_valid_held: got %b want 1", v0); end
    endtask

    task automatic test_abort();
        int cyc, nr, se; logic vo, fa; logic [7:0] fo;
        cur = 1'b0;
        mem0[5] = 8'h41;
        run_pass(300, 1'b0, 0, cyc, nr, se, vo, fo, fa);
        checks++; if (cyc !== 25) begin errors++; $display("FAIL abort_latency: got %0d want 25", cyc); end
        checks++; if (vo !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", vo); end
        checks++; if (fo !== 8'd5) begin errors++; $display("FAIL abort_fail_index: got %0d want 5", fo); end
        checks++; if (nr !== 6 || se !== 0 || a0 !== 8'd5) begin errors++; $display("FAIL abort_reads: got %0d reads last addr %0d, want 6 reads ending at 5", nr, a0); end
        mem0[5] = 8'h66;
    endtask

    task automatic test_space();
        int cyc, nr, se; logic vo, fa; logic [7:0] fo;
        cur = 1'b0;
        mem0[0] = 8'h20;
        run_pass(300, 1'b0, 0, cyc, nr, se, vo, fo, fa);
`ifdef MSG_ALLOW_SPACE_EN
        checks++; if (cyc !== 129 || vo !== 1'b1 || fo !== 8'd0) begin errors++; $display("FAIL space_allowed: got cyc=%0d valid=%b fi=%0d, want 129/1/0", cyc, vo, fo); end
`else
        checks++; if (cyc !== 5 || vo !== 1'b0 || fo !== 8'd0) begin errors++; $display("FAIL space_rejected: got cyc=%0d valid=%b fi=%0d, want 5/0/0", cyc, vo, fo); end
`endif
        mem0[0] = 8'h61;
    endtask

    task automatic test_reset_mid_pass();
        int cyc, nr, se; logic vo, fa; logic [7:0] fo;
        cur = 1'b0;
        @(negedge clk); start_drv = 1'b1;
        @(negedge clk); start_drv = 1'b0;
        repeat (41) @(negedge clk);   // cycle 42: WAIT_DATA of byte 10
        checks++; if (a0 !== 8'd10 || v0 !== 1'b1) begin errors++; $display("FAIL midpass_setup: got addr=%0d valid=%b, want 10/1", a0, v0); end
        reset = 1'b0;
        #1;
        checks++; if ({fin0, v0, f0, a0} !== 18'd0) begin errors++; $display("FAIL midpass_reset: got fin=%b valid=%b fi=%0d addr=%0d, want all 0", fin0, v0, f0, a0); end
        @(negedge clk); reset = 1'b1;
        run_pass(300, 1'b0, 0, cyc, nr, se, vo, fo, fa);
        checks++; if (cyc !== 129 || vo !== 1'b1 || nr !== 32 || se !== 0) begin errors++; $display("FAIL midpass_rerun: got cyc=%0d valid=%b reads=%0d, want 129/1/32", cyc, vo, nr); end
    endtask

    task automatic test_random();
        int cyc, nr, se, fi, reads, poke; bit v; logic vo, fa; logic [7:0] fo;
        cur = 1'b0;
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 32; i++) mem0[i] = rnd_byte();
            model(32, v, fi, reads);
            poke = $urandom_range(20, 2);
            run_pass(300, 1'b0, poke, cyc, nr, se, vo, fo, fa);
            checks++;
            if (cyc !== 4 * reads + 1 || vo !== v || fo !== 8'(fi) || nr !== reads || se !== 0 || fa !== 1'b0) begin
                errors++;
                $display("FAIL random_%0d: got cyc=%0d valid=%b fi=%0d reads=%0d, want cyc=%0d valid=%b fi=%0d reads=%0d",
                         it, cyc, vo, fo, nr, 4 * reads + 1, v, fi, reads);
            end
        end
    endtask

    task automatic test_max_len();
        int cyc, nr, se; logic vo, fa; logic [7:0] fo;
        cur = 1'b1;
        for (int i = 0; i < 256; i++) mem1[i] = 8'h7A;
        mem1[200] = 8'h5B;
        run_pass(1200, 1'b0, 0, cyc, nr, se, vo, fo, fa);
        checks++; if (cyc !== 805 || vo !== 1'b0 || fo !== 8'd200) begin errors++; $display("FAIL max_abort: got cyc=%0d valid=%b fi=%0d, want 805/0/200", cyc, vo, fo); end
        mem1[200] = 8'h7A;
        run_pass(1200, 1'b0, 0, cyc, nr, se, vo, fo, fa);
        checks++; if (cyc !== 1025) begin errors++; $display("FAIL max_latency: got %0d want 1025", cyc); end
        checks++; if (vo !== 1'b1 || fo !== 8'd0) begin errors++; $display("FAIL max_verdict: got valid=%b fi=%0d, want 1/0", vo, fo); end
        checks++; if (nr !== 256 || se !== 0 || a1 !== 8'hFF) begin errors++; $display("FAIL max_reads: got %0d reads last addr %0d, want 256 ending at 255", nr, a1); end
        cur = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc, nr, se, k; logic vo, fa; logic [7:0] fo;
        cur = 1'b0;
        for (int i = 0; i < 32; i++) mem0[i] = 8'h61 + 8'(i % 26);
        run_pass(300, 1'b1, 0, cyc, nr, se, vo, fo, fa);
        checks++; if (cyc !== 129) begin errors++; $display("FAIL b2b_first: got %0d want 129", cyc); end
        for (int p = 0; p < 2; p++) begin
            k = 1;
            while (fin0 !== 1'b1 && k < 400) begin
                @(negedge clk); k++;
            end
            if (p == 1) start_drv = 1'b0;
            checks++; if (k !== 130) begin errors++; $display("FAIL b2b_gap_%0d: finish spacing %0d want 130", p, k); end
            if (p == 0) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        checks++; if (fin0 !== 1'b0 || a0 !== 8'd31 || v0 !== 1'b1) begin errors++; $display("FAIL b2b_stop: got fin=%b addr=%0d valid=%b, want 0/31/1", fin0, a0, v0); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mem0[i] = 8'h61; mem1[i] = 8'h61; end
        test_reset();
        test_all_legal();
        test_abort();
        test_reset_mid_pass();
        test_space();
        test_random();
        test_max_len();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/message_checker.md
MESSAGE_CHECKER -- requirements
Module: message_checker

Interface
REQ-001 Parameter MSG_LEN, default 32: number of decrypted bytes checked, legal range 1..256.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  begin a check pass; sampled only in IDLE.
REQ-005 finish  output  1  one-cycle pulse when the pass ends.
REQ-006 address_d  output  8  D RAM read address, registered.
REQ-007 q_d  input  8  D RAM read data.
REQ-008 valid  output  1  pass verdict: 1 = every byte legal; held until the next start.
REQ-009 fail_index  output  8  index of the first illegal byte; 0 when valid=1.

Function
REQ-010 The block SHALL read D RAM bytes 0..MSG_LEN-1 in ascending order and classify each byte as legal or illegal.
REQ-011 Legal bytes SHALL be 8'h61..8'h7A ('a'..'z'), plus the optional space byte (REQ-024/025).
REQ-012 States SHALL be IDLE, SET_ADDR, WAIT_DATA, CAPTURE, CHECK and DONE.
REQ-013 Transitions SHALL be: IDLE->SET_ADDR on start=1; SET_ADDR->WAIT_DATA->CAPTURE->CHECK unconditionally.
REQ-014 From CHECK the machine SHALL go to DONE on an illegal byte or when index=MSG_LEN-1, and otherwise to SET_ADDR with index+1.
REQ-015 DONE->IDLE unconditionally, and finish=1 only in DONE.
REQ-016 address_d SHALL load index in SET_ADDR.
REQ-017 q_d SHALL be registered in CAPTURE, two clocks after address_d loads (1-cycle registered-address RAM plus 1 wait cycle).
REQ-018 The index counter SHALL be 9 bits wide so MSG_LEN=256 terminates without 8-bit wrap-around; address_d SHALL be its low 8 bits.
REQ-019 On the first illegal byte the block SHALL abort the pass early, set valid=0 and fail_index=index, and perform no further reads.
REQ-020 Latency: an all-legal pass SHALL assert finish 4*MSG_LEN+1 cycles after the clock edge that samples start; an abort at index n SHALL assert finish 4*(n+1)+1 cycles after that edge.
REQ-021 start outside IDLE, including start in the same cycle as finish, SHALL be ignored.
REQ-022 Entering SET_ADDR from IDLE SHALL clear the index to 0 and set valid=1 provisionally; it SHALL NOT change fail_index.

Reset
REQ-023 Asynchronous reset SHALL force state=IDLE, index=0, address_d=0, captured byte=0, finish=0, valid=0 and fail_index=0, including when asserted mid-pass; after release the block SHALL wait for a new start.

Configuration
REQ-024 With macro MSG_ALLOW_SPACE_EN defined, byte 8'h20 SHALL be legal.
REQ-025 Without MSG_ALLOW_SPACE_EN, 8'h20 SHALL be illegal and only 'a'..'z' SHALL pass.

Structure
REQ-026 Package rc4_pkg SHALL hold the state enum and the constants CHAR_LO=8'h61, CHAR_HI=8'h7A and CHAR_SPACE=8'h20, shared with the key-search controller.
REQ-027 Sub-module char_classifier (8-bit in, 1-bit legal out, honouring MSG_ALLOW_SPACE_EN) SHALL be instantiated once.

Verification
REQ-028 MSG_LEN=32, RAM filled with 'a'..'z' repeating, pulse start -> finish at cycle 129, valid=1, fail_index=0, 32 reads at addresses 0..31.
REQ-029 Byte 5 = 8'h41 -> finish at cycle 25, valid=0, fail_index=5, and no read of address 6.
REQ-030 Byte 0 = 8'h20: with MSG_ALLOW_SPACE_EN -> valid=1; without it -> valid=0, fail_index=0.
REQ-031 MSG_LEN=256, all 8'h7A -> finish at cycle 1025, valid=1, and address_d sequence wraps from 8'hFF to no further read.
REQ-032 Assert reset during the WAIT_DATA state of byte 10 -> all outputs 0 immediately; a fresh start then completes a full pass normally.
REQ-033 Hold start high continuously -> passes run back-to-back, with one IDLE cycle between each finish and the next SET_ADDR.
